// File: rtl/l1d_fsm_nway.sv
// l1d_fsm_nway: N-way L1D main controller. It sequences Idle / WriteBus /
// ReadBus / WriteCache, using multi-beat write-back and refill bursts, a latched
// victim way, and an abort path for bus errors.
// Optional build macro L1D_FSM_PERF_EN adds the 32-bit counters perf_hit,
// perf_miss and perf_wb.
module l1d_fsm_nway #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned WAY_W  = 1,
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_rd,
  input  logic              hit,
  input  logic [WAY_W-1:0]  hit_way,
  input  logic [WAY_W-1:0]  victim_way,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic              bus_wr_ready,
  input  logic              bus_rd_valid,
  input  logic              bus_err,
  output logic              bus_wr_req,
  output logic              bus_rd_req,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic              fill_we,
  output logic              cache_we,
  output logic [WAY_W-1:0]  way_sel,
  output logic              core_ready,
  output logic              core_err,
  output logic [1:0]        fsm_state,
  output logic [1:0]        fsm_state_d1
`ifdef L1D_FSM_PERF_EN
  ,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss,
  output logic [31:0]       perf_wb
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WB   = 2'b01,
    S_RB   = 2'b10,
    S_WC   = 2'b11
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Elaboration guard: way index width must cover exactly WAYS ways
  if (WAYS != (32'd1 << WAY_W)) begin : g_bad_ways
    $error("l1d_fsm_nway: WAYS must equal 2**WAY_W");
  end

  state_t            state, state_nx;
  logic [BEAT_W-1:0] beat_r, beat_nx;
  logic [WAY_W-1:0]  way_r, way_nx;
  logic [1:0]        state_d1_r;

  // State, beat counter, latched way and delayed state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      beat_r     <= '0;
      way_r      <= '0;
      state_d1_r <= 2'b00;
    end else begin
      state      <= state_nx;
      beat_r     <= beat_nx;
      way_r      <= way_nx;
      state_d1_r <= state;
    end
  end

  // Next-state logic and strobe decode; bus_err takes priority over ready/valid
  always_comb begin
    state_nx   = state;
    beat_nx    = beat_r;
    way_nx     = way_r;
    bus_wr_req = 1'b0;
    bus_rd_req = 1'b0;
    fill_we    = 1'b0;
    cache_we   = 1'b0;
    core_ready = 1'b0;
    core_err   = 1'b0;
    way_sel    = way_r;
    unique case (state)
      S_IDLE: begin
        way_sel = hit_way;
        if (core_req) begin
          if (hit) begin
            if (core_rd) begin
              core_ready = !rst;
            end else begin
              way_nx   = hit_way;
              state_nx = S_WC;
            end
          end else begin
            way_nx   = victim_way;
            state_nx = (victim_valid && victim_dirty) ? S_WB : S_RB;
          end
        end
      end
      S_WB: begin
        bus_wr_req = 1'b1;
        if (bus_err) begin
          core_err = 1'b1;
          beat_nx  = '0;
          state_nx = S_IDLE;
        end else if (bus_wr_ready) begin
          beat_nx = beat_r + BEAT_W'(1);
          if (beat_r == LAST_BEAT) state_nx = S_RB;
        end
      end
      S_RB: begin
        bus_rd_req = 1'b1;
        if (bus_err) begin
          core_err = 1'b1;
          beat_nx  = '0;
          state_nx = S_IDLE;
        end else if (bus_rd_valid) begin
          fill_we = 1'b1;
          beat_nx = beat_r + BEAT_W'(1);
          if (beat_r == LAST_BEAT) state_nx = S_WC;
        end
      end
      S_WC: begin
        cache_we   = 1'b1;
        core_ready = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign beat_cnt     = beat_r;
  assign fsm_state    = state;
  assign fsm_state_d1 = state_d1_r;

`ifdef L1D_FSM_PERF_EN
  logic hit_acc, miss_acc, wb_done;
  assign hit_acc  = (state == S_IDLE) && core_req && hit;
  assign miss_acc = (state == S_IDLE) && core_req && !hit;
  assign wb_done  = (state == S_WB) && !bus_err && bus_wr_ready && (beat_r == LAST_BEAT);

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
      perf_wb   <= '0;
    end else begin
      if (hit_acc)  perf_hit  <= perf_hit + 32'd1;
      if (miss_acc) perf_miss <= perf_miss + 32'd1;
      if (wb_done)  perf_wb   <= perf_wb + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1d_fsm_nway.sv
// tb_l1d_fsm_nway: randomized transaction-level bench for l1d_fsm_nway.
// Set L1D_FSM_PERF_EN to also check the performance counters.
module tb_l1d_fsm_nway;

  localparam int unsigned WAYS   = 2;
  localparam int unsigned WAY_W  = 1;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned BEAT_W = 2;
  localparam int unsigned OBS_W  = 2 + 2 + BEAT_W + 6 + WAY_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_req, core_rd, hit;
  logic [WAY_W-1:0]  hit_way, victim_way;
  logic              victim_valid, victim_dirty;
  logic              bus_wr_ready, bus_rd_valid, bus_err;
  logic              bus_wr_req, bus_rd_req, fill_we, cache_we, core_ready, core_err;
  logic [BEAT_W-1:0] beat_cnt;
  logic [WAY_W-1:0]  way_sel;
  logic [1:0]        fsm_state, fsm_state_d1;
`ifdef L1D_FSM_PERF_EN
  logic [31:0]       perf_hit, perf_miss, perf_wb;
`endif

  int errors = 0;
  int checks = 0;
  logic [1:0] prev_st;
  int exp_hit = 0, exp_miss = 0, exp_wb = 0;

  l1d_fsm_nway #(.WAYS(WAYS), .WAY_W(WAY_W), .BEATS(BEATS), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_rd(core_rd), .hit(hit),
    .hit_way(hit_way), .victim_way(victim_way), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .bus_wr_ready(bus_wr_ready), .bus_rd_valid(bus_rd_valid),
    .bus_err(bus_err), .bus_wr_req(bus_wr_req), .bus_rd_req(bus_rd_req),
    .beat_cnt(beat_cnt), .fill_we(fill_we), .cache_we(cache_we), .way_sel(way_sel),
    .core_ready(core_ready), .core_err(core_err), .fsm_state(fsm_state),
    .fsm_state_d1(fsm_state_d1)
`ifdef L1D_FSM_PERF_EN
    , .perf_hit(perf_hit), .perf_miss(perf_miss), .perf_wb(perf_wb)
`endif
  );

  always #5 clk = ~clk;

  logic [OBS_W-1:0] obs;
  assign obs = {fsm_state, fsm_state_d1, beat_cnt, bus_wr_req, bus_rd_req,
                fill_we, cache_we, core_ready, core_err, way_sel};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Randomize inputs the controller must ignore outside Idle
  task automatic scramble_core(input bit drop);
    core_req     = drop ? 1'b0 : 1'($urandom);
    core_rd      = 1'($urandom);
    hit          = 1'($urandom);
    hit_way      = WAY_W'($urandom);
    victim_way   = WAY_W'($urandom);
    victim_valid = 1'($urandom);
    victim_dirty = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    core_req = 1'b1; core_rd = 1'b1; hit = 1'b1; hit_way = '0;
    victim_way = '0; victim_valid = 1'b0; victim_dirty = 1'b0;
    bus_wr_ready = 1'b1; bus_rd_valid = 1'b1; bus_err = 1'b1;
    #3;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs, {OBS_W{1'b0}});
    end
    tick();
    rst = 1'b0;
    core_req = 1'b0; bus_err = 1'b0;
    prev_st = 2'b00;
  endtask

  task automatic test_idle_noreq(input int n);
    for (int i = 0; i < n; i++) begin
      scramble_core(1'b1);
      bus_wr_ready = 1'($urandom); bus_rd_valid = 1'($urandom); bus_err = 1'($urandom);
      #2;
      checks++;
      if (obs !== {2'b00, prev_st, BEAT_W'(0), 6'b000000, hit_way}) begin
        errors++; $display("FAIL idle_noreq: got %h want %h", obs,
                           {2'b00, prev_st, BEAT_W'(0), 6'b000000, hit_way});
      end
      tick();
      prev_st = 2'b00;
    end
    bus_err = 1'b0;
  endtask

  task automatic test_read_hit(input int n);
    logic [WAY_W-1:0] hw;
    for (int i = 0; i < n; i++) begin
      hw = (i == 0) ? WAY_W'(1) : WAY_W'($urandom);
      scramble_core(1'b0);
      core_req = 1'b1; core_rd = 1'b1; hit = 1'b1; hit_way = hw;
      bus_wr_ready = 1'($urandom); bus_rd_valid = 1'($urandom); bus_err = 1'($urandom);
      #2;
      checks++;
      if (obs !== {2'b00, prev_st, BEAT_W'(0), 6'b000010, hw}) begin
        errors++; $display("FAIL read_hit: got %h want %h", obs,
                           {2'b00, prev_st, BEAT_W'(0), 6'b000010, hw});
      end
      tick();
      prev_st = 2'b00;
      exp_hit++;
    end
    bus_err = 1'b0;
  endtask

  task automatic test_write_hit(input int n);
    logic [WAY_W-1:0] hw;
    for (int i = 0; i < n; i++) begin
      hw = (i == 0) ? WAY_W'(0) : WAY_W'($urandom);
      scramble_core(1'b0);
      core_req = 1'b1; core_rd = 1'b0; hit = 1'b1; hit_way = hw; bus_err = 1'b0;
      #2;
      checks++;
      if (obs !== {2'b00, prev_st, BEAT_W'(0), 6'b000000, hw}) begin
        errors++; $display("FAIL write_hit_req: got %h want %h", obs,
                           {2'b00, prev_st, BEAT_W'(0), 6'b000000, hw});
      end
      tick();
      exp_hit++;
      scramble_core(1'b0);
      bus_err = 1'($urandom);
      #2;
      checks++;
      if (obs !== {2'b11, 2'b00, BEAT_W'(0), 6'b000110, hw}) begin
        errors++; $display("FAIL write_hit_commit: got %h want %h", obs,
                           {2'b11, 2'b00, BEAT_W'(0), 6'b000110, hw});
      end
      tick();
      prev_st = 2'b11;
      bus_err = 1'b0;
      core_req = 1'b0;
    end
  endtask

  // One miss transaction; pat 0 random, 1 alternate beats, 2 stall first two cycles.
  // err_wb / err_rb give the beat index on which bus_err strikes (-1 = never).
  task automatic run_miss(input string nm, input bit dirty, input logic [WAY_W-1:0] vw,
                          input int pat, input int err_wb, input int err_rb, input bit drop);
    int acc, cyc, stall;
    bit rdy, err;
    logic [WAY_W-1:0] hw;
    hw = WAY_W'($urandom);
    core_req = 1'b1; core_rd = 1'($urandom); hit = 1'b0; hit_way = hw; victim_way = vw;
    if (dirty) begin
      victim_valid = 1'b1; victim_dirty = 1'b1;
    end else begin
      victim_valid = 1'($urandom);
      victim_dirty = victim_valid ? 1'b0 : 1'($urandom);
    end
    bus_wr_ready = 1'($urandom); bus_rd_valid = 1'($urandom); bus_err = 1'b0;
    #2;
    checks++;
    if (obs !== {2'b00, prev_st, BEAT_W'(0), 6'b000000, hw}) begin
      errors++; $display("FAIL %s_req: got %h want %h", nm, obs,
                         {2'b00, prev_st, BEAT_W'(0), 6'b000000, hw});
    end
    tick();
    prev_st = 2'b00;
    exp_miss++;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 0 && !dirty) continue;
      acc = 0; cyc = 0; stall = 0;
      while (acc < int'(BEATS)) begin
        case (pat)
          1:       rdy = cyc[0];
          2:       rdy = (cyc >= 2);
          default: rdy = (stall >= 3) || ($urandom_range(0, 1) == 1);
        endcase
        err = (acc == ((ph == 0) ? err_wb : err_rb));
        scramble_core(drop);
        bus_err = err;
        if (ph == 0) begin
          bus_wr_ready = rdy; bus_rd_valid = 1'($urandom);
        end else begin
          bus_rd_valid = rdy; bus_wr_ready = 1'($urandom);
        end
        #2;
        checks++;
        if (obs !== {(ph == 0) ? 2'b01 : 2'b10, prev_st, BEAT_W'(acc), ph == 0, ph == 1,
                     ph == 1 && rdy && !err, 1'b0, 1'b0, err, vw}) begin
          errors++; $display("FAIL %s_burst%0d_beat%0d: got %h want %h", nm, ph, acc, obs,
                             {(ph == 0) ? 2'b01 : 2'b10, prev_st, BEAT_W'(acc), ph == 0, ph == 1,
                              ph == 1 && rdy && !err, 1'b0, 1'b0, err, vw});
        end
        tick();
        prev_st = (ph == 0) ? 2'b01 : 2'b10;
        cyc++;
        if (err) begin
          bus_err = 1'b0; core_req = 1'b0;
          #2;
          checks++;
          if (obs !== {2'b00, prev_st, BEAT_W'(0), 6'b000000, hit_way}) begin
            errors++; $display("FAIL %s_abort: got %h want %h", nm, obs,
                               {2'b00, prev_st, BEAT_W'(0), 6'b000000, hit_way});
          end
          tick();
          prev_st = 2'b00;
          return;
        end
        if (rdy) begin acc++; stall = 0; end else stall++;
      end
      if (ph == 0) exp_wb++;
    end
    scramble_core(drop);
    bus_err = 1'($urandom);
    #2;
    checks++;
    if (obs !== {2'b11, prev_st, BEAT_W'(0), 6'b000110, vw}) begin
      errors++; $display("FAIL %s_commit: got %h want %h", nm, obs,
                         {2'b11, prev_st, BEAT_W'(0), 6'b000110, vw});
    end
    tick();
    prev_st = 2'b11;
    core_req = 1'b0; bus_err = 1'b0;
    #2;
    checks++;
    if (obs !== {2'b00, prev_st, BEAT_W'(0), 6'b000000, hit_way}) begin
      errors++; $display("FAIL %s_done: got %h want %h", nm, obs,
                         {2'b00, prev_st, BEAT_W'(0), 6'b000000, hit_way});
    end
    tick();
    prev_st = 2'b00;
  endtask

  task automatic test_back_to_back(input int n);
    int kind;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: test_read_hit(1);
        1: test_write_hit(1);
        2: run_miss("rnd_clean", 1'b0, WAY_W'($urandom), 0, -1,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, BEATS - 1) : -1, 1'($urandom));
        default: run_miss("rnd_dirty", 1'b1, WAY_W'($urandom), 0,
                          ($urandom_range(0, 4) == 0) ? $urandom_range(0, BEATS - 1) : -1,
                          ($urandom_range(0, 4) == 0) ? $urandom_range(0, BEATS - 1) : -1,
                          1'($urandom));
      endcase
    end
  endtask

  task automatic test_reset_mid_burst();
    core_req = 1'b1; core_rd = 1'b0; hit = 1'b0; hit_way = '0; victim_way = WAY_W'(1);
    victim_valid = 1'b1; victim_dirty = 1'b1; bus_err = 1'b0; bus_wr_ready = 1'b1;
    tick();
    tick();
    bus_wr_ready = 1'b0;
    #1;
    checks++;
    if ({fsm_state, beat_cnt, bus_wr_req} !== {2'b01, BEAT_W'(1), 1'b1}) begin
      errors++; $display("FAIL rst_pre_beat1: got %h want %h",
                         {fsm_state, beat_cnt, bus_wr_req}, {2'b01, BEAT_W'(1), 1'b1});
    end
    core_req = 1'b1; core_rd = 1'b1; hit = 1'b1; hit_way = '0;
    bus_rd_valid = 1'b1; bus_err = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL rst_async: got %h want %h", obs, {OBS_W{1'b0}});
    end
    tick();
    rst = 1'b0; core_req = 1'b0; bus_err = 1'b0;
    prev_st = 2'b00;
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
  endtask

  task automatic test_perf();
`ifdef L1D_FSM_PERF_EN
    #1;
    checks++;
    if ({perf_hit, perf_miss, perf_wb} !== {32'(exp_hit), 32'(exp_miss), 32'(exp_wb)}) begin
      errors++; $display("FAIL perf: got %0d/%0d/%0d want %0d/%0d/%0d",
                         perf_hit, perf_miss, perf_wb, exp_hit, exp_miss, exp_wb);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_idle_noreq(4);
    test_read_hit(6);
    test_write_hit(4);
    run_miss("clean_alt", 1'b0, WAY_W'($urandom), 1, -1, -1, 1'b0);
    run_miss("dirty_stall", 1'b1, WAY_W'(1), 2, -1, -1, 1'b1);
    run_miss("err_rd2", 1'b0, WAY_W'($urandom), 0, -1, 2, 1'b0);
    test_read_hit(1);
    run_miss("err_wb1", 1'b1, WAY_W'($urandom), 0, 1, -1, 1'b0);
    test_back_to_back(30);
    test_perf();
    test_reset_mid_burst();
    test_perf();
    test_read_hit(2);
    test_write_hit(1);
    run_miss("perf_dirty", 1'b1, WAY_W'(1), 0, -1, -1, 1'b0);
    run_miss("perf_clean", 1'b0, WAY_W'(0), 0, -1, -1, 1'b0);
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
